// File: rtl/xrv_pkg.sv
// Shared types for the xrv memory arbiter: response-tracking states.
package xrv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        RSP_IDLE,
        RSP_I,
        RSP_DRD,
        RSP_DWR,
        RSP_DERR
    } rsp_state_e;

endpackage

// File: rtl/xrv_mem_arb_prio.sv
// Grant decision between fetch and LSU. The LSU wins by default.
// A starvation counter forces one fetch grant after STARVE_MAX lost fetch cycles.
module xrv_mem_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic i_req_ok,
    input  logic d_req,
    output logic gnt_i,
    output logic gnt_d
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_MAX);
    assign gnt_d   = d_req & ~(i_req_ok & starved);
    assign gnt_i   = i_req_ok & ~gnt_d;

    // When a valid fetch is not granted, the LSU was granted: count it as a loss.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            starve_cnt <= '0;
        end else if (!i_req_ok || gnt_i) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/xrv_mem_arb.sv
// Shares one 1-cycle-latency single-port SRAM between instruction fetch and LSU.
// Tracks the owner of each access so the read data is routed back one cycle later.
module xrv_mem_arb
    import xrv_pkg::*;
#(
    parameter int          MEM_AW     = 14,
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    input  logic              i_flush,
    output logic              i_gnt,
    output logic [31:0]       i_rdata,
    output logic              i_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic [31:0]       d_rdata,
    output logic              d_rvalid,
    output logic              d_err,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [32:0] WIN_BYTES = 33'd1 << (MEM_AW + 2);

    logic        i_req_ok;
    logic        gnt_i;
    logic        gnt_d;
    logic        d_inwin;
    logic [31:0] d_off;
    logic [31:0] i_off;
    logic [31:0] g_off;
    logic        unused_off;
    rsp_state_e  rsp_state;

    assign i_req_ok = i_req & ~i_flush;

    xrv_mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .rstb    (rstb),
        .i_req_ok(i_req_ok),
        .d_req   (d_req),
        .gnt_i   (gnt_i),
        .gnt_d   (gnt_d)
    );

    assign i_gnt = gnt_i;
    assign d_gnt = gnt_d;

    // Window test is done on the rebased offset with one spare bit so the
    // largest windows do not overflow the 32-bit compare.
    assign d_off   = d_addr - BASE_ADDR;
    assign i_off   = i_addr - BASE_ADDR;
    assign d_inwin = ({1'b0, d_off} < WIN_BYTES);
    assign g_off   = gnt_d ? d_off : i_off;

    assign mem_cs     = gnt_i | (gnt_d & d_inwin);
    assign mem_we     = gnt_d & d_we;
    assign mem_be     = (gnt_d & d_we) ? d_be : 4'hF;
    assign mem_addr   = g_off[MEM_AW+1:2];
    assign mem_wdata  = d_wdata;
    assign unused_off = ^{g_off[31:MEM_AW+2], g_off[1:0]};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rsp_state <= RSP_IDLE;
        end else if (gnt_i) begin
            rsp_state <= RSP_I;
        end else if (gnt_d) begin
            if (!d_inwin)
                rsp_state <= RSP_DERR;
            else if (d_we)
                rsp_state <= RSP_DWR;
            else
                rsp_state <= RSP_DRD;
        end else begin
            rsp_state <= RSP_IDLE;
        end
    end

    // SRAM data only exists in the response cycle, so routing is combinational on the state.
    assign i_rvalid = (rsp_state == RSP_I) & ~i_flush;
    assign i_rdata  = (rsp_state == RSP_I) ? mem_rdata : 32'h0;
    assign d_rvalid = (rsp_state == RSP_DRD) | (rsp_state == RSP_DWR) | (rsp_state == RSP_DERR);
    assign d_err    = (rsp_state == RSP_DERR);
    assign d_rdata  = (rsp_state == RSP_DRD) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_xrv_mem_arb.sv
// Randomized bench for xrv_mem_arb with an SRAM model and a transaction-level reference.
module tb_xrv_mem_arb;

    localparam int          MEM_AW     = 14;
    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] BASE_ADDR  = 32'h0;
    localparam int          NWORDS     = 1 << MEM_AW;

    localparam int P_NONE = 0;
    localparam int P_I    = 1;
    localparam int P_DRD  = 2;
    localparam int P_DWR  = 3;
    localparam int P_ERR  = 4;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              i_req = 1'b0;
    logic [31:0]       i_addr = '0;
    logic              i_flush = 1'b0;
    logic              i_gnt;
    logic [31:0]       i_rdata;
    logic              i_rvalid;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [3:0]        d_be = '0;
    logic [31:0]       d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic              d_gnt;
    logic [31:0]       d_rdata;
    logic              d_rvalid;
    logic              d_err;
    logic              mem_cs;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;

    logic [31:0] sram    [NWORDS];
    logic [31:0] ref_mem [NWORDS];

    int          n_checks = 0;
    int          n_errors = 0;
    int          starve   = 0;
    int          pend     = P_NONE;
    logic [31:0] pend_data = '0;

    xrv_mem_arb #(
        .MEM_AW    (MEM_AW),
        .STARVE_MAX(STARVE_MAX),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_flush  (i_flush),
        .i_gnt    (i_gnt),
        .i_rdata  (i_rdata),
        .i_rvalid (i_rvalid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rdata  (d_rdata),
        .d_rvalid (d_rvalid),
        .d_err    (d_err),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // SRAM: one access per cycle, read data on the following cycle.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) sram[mem_addr] <= byte_merge(sram[mem_addr], mem_wdata, mem_be);
            else        mem_rdata <= sram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return int'((off >> 2) % NWORDS);
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return longint'(off) < (longint'(1) << (MEM_AW + 2));
    endfunction

    // One clock cycle: drive inputs, check last cycle's response and this cycle's grant.
    task automatic cyc(input bit ir, input logic [31:0] ia, input bit fl, input bit dr, input bit dw,
                       input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
        bit i_ok, gd, gi, inwin, cs;
        int w;
        @(negedge clk);
        i_req = ir; i_addr = ia; i_flush = fl;
        d_req = dr; d_we = dw; d_be = be; d_addr = da; d_wdata = wd;
        #1;
        chk("i_rvalid", 32'(i_rvalid), 32'(pend == P_I && !fl));
        chk("i_rdata",  i_rdata, (pend == P_I) ? pend_data : 32'h0);
        chk("d_rvalid", 32'(d_rvalid), 32'(pend == P_DRD || pend == P_DWR || pend == P_ERR));
        chk("d_err",    32'(d_err), 32'(pend == P_ERR));
        chk("d_rdata",  d_rdata, (pend == P_DRD) ? pend_data : 32'h0);

        i_ok  = ir && !fl;
        gd    = dr && !(i_ok && starve == STARVE_MAX);
        gi    = i_ok && !gd;
        inwin = in_window(da);
        cs    = gi || (gd && inwin);
        chk("i_gnt",     32'(i_gnt), 32'(gi));
        chk("d_gnt",     32'(d_gnt), 32'(gd));
        chk("mem_cs",    32'(mem_cs), 32'(cs));
        chk("mem_we",    32'(mem_we), 32'(gd && dw));
        chk("mem_be",    32'(mem_be), (gd && dw) ? 32'(be) : 32'hF);
        chk("mem_wdata", mem_wdata, wd);
        if (cs) chk("mem_addr", 32'(mem_addr), 32'(word_of(gd ? da : ia)));

        if (!i_ok || gi)              starve = 0;
        else if (starve < STARVE_MAX) starve++;

        pend = P_NONE;
        pend_data = '0;
        if (gi) begin
            pend = P_I;
            pend_data = ref_mem[word_of(ia)];
        end else if (gd) begin
            w = word_of(da);
            if (!inwin) begin
                pend = P_ERR;
            end else if (dw) begin
                pend = P_DWR;
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
            end else begin
                pend = P_DRD;
                pend_data = ref_mem[w];
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_i_rvalid"}, 32'(i_rvalid), 32'h0);
        chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'h0);
        chk({tag, "_d_err"},    32'(d_err), 32'h0);
        chk({tag, "_i_rdata"},  i_rdata, 32'h0);
        chk({tag, "_d_rdata"},  d_rdata, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) < 8) return 32'($urandom_range(0, 255));
        return $urandom();
    endfunction

    initial begin
        logic [5:0] gpat;
        int dpct;
        for (int k = 0; k < NWORDS; k++) begin
            sram[k]    = 32'h9E37_79B9 * 32'(k + 1);
            ref_mem[k] = sram[k];
        end

        // Reset state
        #12;
        check_quiet("reset");
        @(negedge clk);
        rstb = 1'b1;

        // Fetch-only read
        sram[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        cyc(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("fetch_gnt", 32'(i_gnt), 32'h1);
        chk("fetch_addr", 32'(mem_addr), 32'h4);
        idle();
        chk("fetch_rvalid", 32'(i_rvalid), 32'h1);
        chk("fetch_rdata", i_rdata, 32'hDEAD_BEEF);

        // Starvation: both request for six cycles
        gpat = '0;
        for (int c = 0; c < 6; c++) begin
            cyc(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
            gpat[c] = i_gnt;
        end
        chk("starve_pattern", 32'(gpat), 32'h10);
        idle();

        // Partial write then read back
        sram[2] = 32'hAAAA_AAAA;
        ref_mem[2] = 32'hAAAA_AAAA;
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h8, 32'h1234_5678);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
        chk("wr_ack_rvalid", 32'(d_rvalid), 32'h1);
        chk("wr_ack_rdata", d_rdata, 32'h0);
        idle();
        chk("rd_back", d_rdata, 32'hAAAA_5678);

        // Flush kills a response and blocks a grant
        cyc(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc(1'b1, 32'h34, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("flush_rvalid", 32'(i_rvalid), 32'h0);
        chk("flush_gnt", 32'(i_gnt), 32'h0);
        chk("flush_cs", 32'(mem_cs), 32'h0);
        cyc(1'b1, 32'h34, 1'b1, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
        chk("flush_dgnt", 32'(d_gnt), 32'h1);
        idle();

        // Out-of-window LSU read
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0001_0000, 32'h0);
        chk("oow_gnt", 32'(d_gnt), 32'h1);
        chk("oow_cs", 32'(mem_cs), 32'h0);
        idle();
        chk("oow_err", 32'(d_err), 32'h1);
        chk("oow_rvalid", 32'(d_rvalid), 32'h1);

        // Reset in the response cycle of a granted read
        for (int c = 0; c < 2; c++)
            cyc(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h48, 32'h0);
        @(negedge clk);
        rstb = 1'b0;
        i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0; d_we = 1'b0;
        #1;
        check_quiet("midrst");
        pend = P_NONE;
        starve = 0;
        @(negedge clk);
        rstb = 1'b1;
        idle();
        for (int c = 0; c < 6; c++)
            cyc(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);

        // Random traffic with alternating LSU pressure
        for (int c = 0; c < 3000; c++) begin
            dpct = ((c / 200) % 2 == 0) ? 50 : 90;
            cyc($urandom_range(0, 99) < 70, rand_addr(), $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < dpct, $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 15)), rand_addr(), $urandom());
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xrv_mem_arb.md
Name: xrv_mem_arb

Overview:
Arbiter sharing one single-port, 1-cycle-latency SRAM between the instruction fetcher and the load/store unit. Data accesses win by default. A starvation counter forces a fetch grant after STARVE_MAX consecutive lost fetch cycles. A response-tracking FSM routes the read data back to the owner. Fetch responses are killed on a jump flush, and out-of-range data accesses are reported as errors.

Parameters:
MEM_AW, 14, SRAM word-address width; byte window is 0 .. 2^(MEM_AW+2)-1
STARVE_MAX, 4, consecutive lost fetch cycles before fetch is forced; legal range >=1
BASE_ADDR, 32'h0, byte base address of the SRAM window; aligned to 2^(MEM_AW+2)

Ports:
clk  in  1  clock
rstb  in  1  asynchronous active-low reset
i_req  in  1  fetch word request
i_addr  in  32  fetch byte address; [1:0] ignored
i_flush  in  1  jump flush from fetcher
i_gnt  out  1  fetch request accepted this cycle
i_rdata  out  32  fetch read data
i_rvalid  out  1  fetch response valid
d_req  in  1  LSU request
d_we  in  1  1=write, 0=read
d_be  in  4  byte enables (write)
d_addr  in  32  LSU byte address; [1:0] ignored
d_wdata  in  32  write data
d_gnt  out  1  LSU request accepted this cycle
d_rdata  out  32  LSU read data
d_rvalid  out  1  LSU response/ack valid
d_err  out  1  qualifies d_rvalid: access out of window
mem_cs  out  1  SRAM select
mem_we  out  1  SRAM write
mem_be  out  4  SRAM byte enables
mem_addr  out  MEM_AW  SRAM word address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data, valid cycle after mem_cs

Behaviour:
- Reset: rsp_state=RSP_IDLE, starve_cnt=0. i_rvalid, d_rvalid and d_err are 0. i_rdata and d_rdata are 0.
- Grant is combinational in request cycle N. The response arrives at N+1 with fixed latency 1. No backpressure on responses.
- i_req_ok = i_req & ~i_flush. A fetch is never granted in a flush cycle.
- d_inwin = (d_addr - BASE_ADDR) < 2^(MEM_AW+2), unsigned 32-bit compare.
- Grant rules:
  - d_req & ~i_req_ok: LSU granted.
  - i_req_ok & ~d_req: fetch granted.
  - Both requesting: fetch is granted iff starve_cnt==STARVE_MAX; otherwise LSU is granted.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when i_req_ok is high and the LSU is granted.
  - Cleared when fetch is granted or when i_req_ok=0.
- SRAM drive on grant:
  - mem_cs=1 for a fetch grant, or an LSU grant with d_inwin.
  - mem_cs=0 for an out-of-window LSU grant.
  - mem_we=d_we only on an LSU grant, else 0. mem_be=d_be for an LSU write, else 4'hF.
  - mem_addr = (granted addr - BASE_ADDR)[MEM_AW+1:2].
  - mem_wdata=d_wdata.
- Response FSM (rsp_state, registered; next state chosen from the grant in cycle N):
  - RSP_IDLE: no grant.
  - RSP_I: fetch granted.
  - RSP_DRD: in-window LSU read.
  - RSP_DWR: in-window LSU write.
  - RSP_DERR: out-of-window LSU access.
- Outputs in cycle N+1 by state:
  - RSP_I: i_rvalid=~i_flush, i_rdata=mem_rdata. A flush in N+1 kills the response.
  - RSP_DRD: d_rvalid=1, d_rdata=mem_rdata.
  - RSP_DWR: d_rvalid=1, d_rdata=0.
  - RSP_DERR: d_rvalid=1, d_err=1, d_rdata=0.
  - All other outputs in those cycles are 0.
- Back-to-back grants every cycle are legal. The FSM state is overwritten each cycle.
- i_flush never affects LSU grants or LSU responses.
- Reset mid-operation: the pending response is dropped and no rvalid follows. The SRAM is not reset.

Decomposition:
- xrv_pkg: rsp_state_e enum (RSP_IDLE, RSP_I, RSP_DRD, RSP_DWR, RSP_DERR).
- Sub-module xrv_mem_arb_prio holds the starvation counter and the grant decision. It is parameterised by STARVE_MAX and outputs gnt_i/gnt_d.
- The response FSM and the SRAM muxing stay in the top module.

Test Plan:
- Fetch only, i_addr=0x10, mem[4]=0xDEADBEEF: i_gnt=1 at N; i_rvalid=1, i_rdata=0xDEADBEEF at N+1; mem_addr=4.
- i_req held high, d_req high for 6 cycles, STARVE_MAX=4: d_gnt in cycles 0-3, i_gnt in cycle 4, d_gnt in cycle 5; starve_cnt back to 0 after cycle 4.
- LSU write d_addr=0x8, d_be=4'b0011, d_wdata=0x12345678, then read of 0x8 (prior 0xAAAAAAAA): d_rvalid ack with d_rdata=0, then d_rdata=0xAAAA5678.
- Fetch granted at N with i_flush=1 at N+1: i_rvalid=0 at N+1. Fetch request with i_flush=1 at N: i_gnt=0, mem_cs=0 unless the LSU is granted.
- LSU read d_addr=0x10000 with MEM_AW=14: d_gnt=1, mem_cs=0; at N+1 d_rvalid=1, d_err=1, d_rdata=0.
- rstb asserted in cycle N+1 after a granted LSU read: all rvalids 0; after release, rsp_state=RSP_IDLE and starve_cnt=0.
